// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: widths, off patterns, glyph table and buffer layout.
package seg7_pkg;

    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned GLYPH_W    = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;
    localparam logic [AN_W-1:0]  AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [GLYPH_W-1:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [NUM_DIGITS*NIB_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       blank;
        logic [NUM_DIGITS-1:0]       dp;
    } disp_cfg_t;

    typedef struct packed {
        disp_cfg_t d0;
        disp_cfg_t d1;
    } frame_buf_t;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble,
                                                    input logic             dp);
        return {~dp, GLYPH[nibble]};
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timing for the digit scan: tick counter within a slot and the 2-bit slot index.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned BLANK_TICKS = 2000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             in_blank,
    output logic             slot_end,
    output logic             frame_end
);

    localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;

    assign slot_end  = (cnt == CNT_LAST);
    assign in_blank  = (cnt < CNT_BLANK);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Double-buffered, time-multiplexed driver for two 4-digit common-anode displays
// scanned in lockstep, with an anode-off interval at the start of every slot.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned BLANK_TICKS = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*NIB_W-1:0] d0_digits,
    input  logic [NUM_DIGITS*NIB_W-1:0] d1_digits,
    input  logic [NUM_DIGITS-1:0]       d0_blank,
    input  logic [NUM_DIGITS-1:0]       d1_blank,
    input  logic [NUM_DIGITS-1:0]       d0_dp,
    input  logic [NUM_DIGITS-1:0]       d1_dp,
    input  logic                        load,
    output logic [SEG_W-1:0]            D0_seg,
    output logic [AN_W-1:0]             D0_a,
    output logic [SEG_W-1:0]            D1_seg,
    output logic [AN_W-1:0]             D1_a,
    output logic                        frame_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0] idx;
    logic             in_blank;
    logic             slot_end;
    logic             frame_end;
    logic             swap_edge;

    frame_buf_t in_buf;
    frame_buf_t act_q;
    frame_buf_t pend_q;
    logic       pend_valid_q;

    logic [SEG_W-1:0] d0_seg_c;
    logic [AN_W-1:0]  d0_a_c;
    logic [SEG_W-1:0] d1_seg_c;
    logic [AN_W-1:0]  d1_a_c;
    logic [AN_W-1:0]  an_sel_c;

    seg7_scan_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .in_blank  (in_blank),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    assign in_buf    = {d0_digits, d0_blank, d0_dp, d1_digits, d1_blank, d1_dp};
    assign swap_edge = slot_end && (idx == IDX_LAST);
    assign an_sel_c  = ~(AN_W'(1) << idx);

    // Next segment/anode values for the current slot, both displays decoded side by side
    always_comb begin
        d0_seg_c = SEG_OFF;
        d0_a_c   = AN_OFF;
        d1_seg_c = SEG_OFF;
        d1_a_c   = AN_OFF;
        if (!in_blank) begin
            if (!act_q.d0.blank[idx]) begin
                d0_a_c   = an_sel_c;
                d0_seg_c = hex_to_seg(act_q.d0.digits[{idx, 2'b00} +: NIB_W], act_q.d0.dp[idx]);
            end
            if (!act_q.d1.blank[idx]) begin
                d1_a_c   = an_sel_c;
                d1_seg_c = hex_to_seg(act_q.d1.digits[{idx, 2'b00} +: NIB_W], act_q.d1.dp[idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            D0_seg       <= SEG_OFF;
            D0_a         <= AN_OFF;
            D1_seg       <= SEG_OFF;
            D1_a         <= AN_OFF;
            frame_done   <= 1'b0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            D0_seg     <= d0_seg_c;
            D0_a       <= d0_a_c;
            D1_seg     <= d1_seg_c;
            D1_a       <= d1_a_c;
            frame_done <= frame_end;
            // A load on the wrap edge bypasses the pending buffer
            if (load && swap_edge) begin
                act_q        <= in_buf;
                pend_valid_q <= 1'b0;
            end else if (load) begin
                pend_q       <= in_buf;
                pend_valid_q <= 1'b1;
            end else if (swap_edge && pend_valid_q) begin
                act_q        <= pend_q;
                pend_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with short slots (8 ticks, 2 blank).
module tb_seven_seg_scanner;

    localparam int DT = 8;
    localparam int BT = 2;

    logic        clk;
    logic        rst;
    logic [15:0] d0_digits, d1_digits;
    logic [3:0]  d0_blank, d1_blank, d0_dp, d1_dp;
    logic        load;
    logic [7:0]  D0_seg, D1_seg;
    logic [3:0]  D0_a, D1_a;
    logic        frame_done;

    seven_seg_scanner #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clk        (clk),
        .rst        (rst),
        .d0_digits  (d0_digits),
        .d1_digits  (d1_digits),
        .d0_blank   (d0_blank),
        .d1_blank   (d1_blank),
        .d0_dp      (d0_dp),
        .d1_dp      (d1_dp),
        .load       (load),
        .D0_seg     (D0_seg),
        .D0_a       (D0_a),
        .D1_seg     (D1_seg),
        .D1_a       (D1_a),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] s0;
        logic [3:0] a0;
        logic [7:0] s1;
        logic [3:0] a1;
        logic       fd;
        logic       rs;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [11:0] disp_out(input logic [15:0] dig, input logic [3:0] blk,
                                             input logic [3:0] dp, input int cnt, input int idx);
        logic [3:0] nib;
        logic [3:0] an;
        if (cnt < BT || blk[idx]) return 12'hFFF;
        nib = dig[idx*4 +: 4];
        an  = 4'hF;
        an[idx] = 1'b0;
        return {~dp[idx], glyph(nib), an};
    endfunction

    // Reference model: expected registered outputs produced by each clock edge
    int          m_cnt, m_idx;
    logic [15:0] m_dig [2];
    logic [3:0]  m_blk [2];
    logic [3:0]  m_dp  [2];
    logic [15:0] p_dig [2];
    logic [3:0]  p_blk [2];
    logic [3:0]  p_dp  [2];
    bit          m_pv;
    bit          m_wrap;
    exp_t        m_e;

    always @(posedge clk) begin
        if (rst) begin
            m_e = '{s0: 8'hFF, a0: 4'hF, s1: 8'hFF, a1: 4'hF, fd: 1'b0, rs: 1'b1};
            m_cnt = 0; m_idx = 0; m_pv = 0;
            for (int k = 0; k < 2; k++) begin
                m_dig[k] = '0; m_blk[k] = '0; m_dp[k] = '0;
                p_dig[k] = '0; p_blk[k] = '0; p_dp[k] = '0;
            end
        end else begin
            {m_e.s0, m_e.a0} = disp_out(m_dig[0], m_blk[0], m_dp[0], m_cnt, m_idx);
            {m_e.s1, m_e.a1} = disp_out(m_dig[1], m_blk[1], m_dp[1], m_cnt, m_idx);
            m_wrap  = (m_cnt == DT - 1) && (m_idx == 3);
            m_e.fd  = m_wrap;
            m_e.rs  = 1'b0;
            if (load && m_wrap) begin
                m_dig[0] = d0_digits; m_blk[0] = d0_blank; m_dp[0] = d0_dp;
                m_dig[1] = d1_digits; m_blk[1] = d1_blank; m_dp[1] = d1_dp;
                m_pv = 0;
            end else if (load) begin
                p_dig[0] = d0_digits; p_blk[0] = d0_blank; p_dp[0] = d0_dp;
                p_dig[1] = d1_digits; p_blk[1] = d1_blank; p_dp[1] = d1_dp;
                m_pv = 1;
            end else if (m_wrap && m_pv) begin
                m_dig = p_dig; m_blk = p_blk; m_dp = p_dp;
                m_pv = 0;
            end
            if (m_cnt == DT - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb_q.push_back(m_e);
    end

    // Scoreboard compare plus frame_done period tracking
    exp_t c_e;
    int   cyc = 0;
    int   fd_last = -1;

    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            c_e = sb_q.pop_front();
            chk("sb_d0_seg", 32'(D0_seg), 32'(c_e.s0));
            chk("sb_d0_a", 32'(D0_a), 32'(c_e.a0));
            chk("sb_d1_seg", 32'(D1_seg), 32'(c_e.s1));
            chk("sb_d1_a", 32'(D1_a), 32'(c_e.a1));
            chk("sb_frame_done", 32'(frame_done), 32'(c_e.fd));
            if (c_e.rs) begin
                fd_last = -1;
            end else if (frame_done) begin
                if (fd_last >= 0) chk("fd_period", 32'(cyc - fd_last), 32'd32);
                fd_last = cyc;
            end
        end
    end

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen = 0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        if (!seen) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    // Wait until D1 lights digit i, then check both displays
    task automatic check_digit(input string tag, input int i, input logic [7:0] s0,
                               input logic [3:0] a0, input logic [7:0] s1);
        logic [3:0] key;
        bit         seen = 0;
        key = 4'hF;
        key[i] = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (D1_a == key) seen = 1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_d0_seg"}, 32'(D0_seg), 32'(s0));
            chk({tag, "_d0_a"}, 32'(D0_a), 32'(a0));
            chk({tag, "_d1_seg"}, 32'(D1_seg), 32'(s1));
        end
    endtask

    int fd_cnt;

    initial begin
        rst = 1'b1; load = 1'b0;
        d0_digits = '0; d1_digits = '0;
        d0_blank = '0; d1_blank = '0; d0_dp = '0; d1_dp = '0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_d0_seg", 32'(D0_seg), 32'hFF);
            chk("rst_d0_a", 32'(D0_a), 32'hF);
            chk("rst_d1_seg", 32'(D1_seg), 32'hFF);
            chk("rst_d1_a", 32'(D1_a), 32'hF);
            chk("rst_fd", 32'(frame_done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk); chk("first_an_1", 32'(D0_a), 32'hF);
        @(negedge clk); chk("first_an_2", 32'(D0_a), 32'hF);
        @(negedge clk); chk("first_an_3", 32'(D0_a), 32'hE);
        chk("first_seg_3", 32'(D0_seg), 32'hC0);

        // Load mid-stream: current frame keeps zeros, next frame shows the new data
        wait_frame();
        d0_digits = 16'h4321; d1_digits = 16'hBEEF;
        pulse_load();
        check_digit("old_frame", 1, 8'hC0, 4'hD, 8'hC0);
        wait_frame();
        check_digit("new_dig0", 0, 8'hF9, 4'hE, 8'h8E);
        check_digit("new_dig1", 1, 8'hA4, 4'hD, 8'h86);
        check_digit("new_dig2", 2, 8'hB0, 4'hB, 8'h86);
        check_digit("new_dig3", 3, 8'h99, 4'h7, 8'h83);

        // Decimal point on digit 0, digit 2 of D0 blanked
        wait_frame();
        d0_dp = 4'b0001; d0_blank = 4'b0100;
        pulse_load();
        wait_frame();
        check_digit("dp_dig0", 0, 8'h79, 4'hE, 8'h8E);
        check_digit("blank_dig2", 2, 8'hFF, 4'hF, 8'h86);
        check_digit("after_blank", 3, 8'h99, 4'h7, 8'h83);

        // Two loads in one frame: last one wins
        wait_frame();
        d0_dp = '0; d0_blank = '0;
        d0_digits = 16'h1111; d1_digits = 16'h0000;
        pulse_load();
        repeat (3) @(negedge clk);
        d0_digits = 16'h2222;
        pulse_load();
        wait_frame();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] an;
            an = 4'hF;
            an[i] = 1'b0;
            check_digit("last_wins", i, 8'hA4, an, 8'hC0);
        end

        // Load coinciding with the frame-wrap edge
        wait_frame();
        repeat (31) @(negedge clk);
        d0_digits = 16'h5678; d1_digits = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrap_load_fd", 32'(frame_done), 32'd1);
        check_digit("wrap_load", 0, 8'h80, 4'hE, 8'h99);

        // Blank interval at slot start and frame_done rate
        wait_frame();
        @(negedge clk); chk("blank_iv_1", 32'(D1_a), 32'hF);
        @(negedge clk); chk("blank_iv_2", 32'(D1_a), 32'hF);
        @(negedge clk); chk("blank_iv_3", 32'(D1_a), 32'hE);
        fd_cnt = 0;
        repeat (96) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
        chk("fd_count", 32'(fd_cnt), 32'd3);

        // Reset in the middle of slot 2
        wait_frame();
        repeat (19) @(negedge clk);
        chk("pre_rst_an", 32'(D1_a), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_d0_seg", 32'(D0_seg), 32'hFF);
        chk("mid_rst_d0_a", 32'(D0_a), 32'hF);
        chk("mid_rst_d1_seg", 32'(D1_seg), 32'hFF);
        chk("mid_rst_d1_a", 32'(D1_a), 32'hF);
        rst = 1'b0;
        check_digit("post_rst0", 0, 8'hC0, 4'hE, 8'hC0);
        check_digit("post_rst1", 1, 8'hC0, 4'hD, 8'hC0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
